// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Holds the FSM state encoding, default sizing and the length-mask builder.
package seq_det_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_LEN_W   = 4;
  localparam int unsigned DEF_CNT_W   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  // Ones in the low `len` bit positions; saturates to all-ones at 32 and above.
  function automatic logic [31:0] len_mask(input int unsigned len);
    if (len >= 32) begin
      return '1;
    end
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats a same-cycle increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// input qualifier and a saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic               in_valid_i,
  input  logic               in_bit_i,
  input  logic               count_clr_i,
  output logic               match_o,
  output logic [CNT_W-1:0]   match_count_o,
  output logic               armed_o,
  output logic               cfg_err_o
);

  state_e             state_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic               match_q;
  logic               cfg_err_q;

  logic [MAX_LEN-1:0] hist_d;
  logic [LEN_W-1:0]   fill_d;
  logic [LEN_W:0]     fill_inc_c;
  logic [MAX_LEN-1:0] mask_c;
  logic               cfg_ok_c;
  logic               sample_c;
  logic               full_c;
  logic               hit_c;

  // A load always wins over a bit arriving in the same cycle.
  assign cfg_ok_c   = (cfg_len_i != '0) && (32'(cfg_len_i) <= MAX_LEN);
  assign sample_c   = (state_q == ARMED) && in_valid_i && !cfg_load_i;

  assign hist_d     = {hist_q[MAX_LEN-2:0], in_bit_i};
  assign fill_inc_c = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign full_c     = (fill_inc_c >= {1'b0, len_q});
  assign fill_d     = full_c ? len_q : fill_inc_c[LEN_W-1:0];

  // Only the low len bits take part in the compare.
  assign mask_c     = MAX_LEN'(len_mask(32'(len_q)));
  assign hit_c      = sample_c && full_c && (((hist_d ^ pattern_q) & mask_c) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      if (cfg_load_i) begin
        hist_q <= '0;
        fill_q <= '0;
        if (cfg_ok_c) begin
          state_q   <= ARMED;
          pattern_q <= cfg_pattern_i;
          len_q     <= cfg_len_i;
          overlap_q <= cfg_overlap_i;
        end else begin
          state_q   <= IDLE;
          cfg_err_q <= 1'b1;
        end
      end else if (sample_c) begin
        hist_q <= hist_d;
        // Non-overlap restarts the fill so stale history cannot rematch.
        if (hit_c) begin
          match_q <= 1'b1;
          fill_q  <= overlap_q ? fill_d : '0;
        end else begin
          fill_q  <= fill_d;
        end
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (hit_c),
    .clr_i   (count_clr_i),
    .count_o (match_count_o)
  );

  assign match_o   = match_q;
  assign armed_o   = (state_q == ARMED);
  assign cfg_err_o = cfg_err_q;

endmodule
